// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between operand source, alu_seq and writeback
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opCode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    // Producer/consumer side of the ALU (register-file read ports and writeback).
    modport master (
        output in_valid,
        output opCode,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  result,
        input  zero,
        input  carry,
        input  overflow,
        input  out_valid,
        input  busy
    );

    // The ALU itself.
    modport slave (
        input  in_valid,
        input  opCode,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output result,
        output zero,
        output carry,
        output overflow,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered single-entry output and multi-cycle multiply
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic    clk,
    input logic    rst,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_DEC = 4'b0010;
    localparam logic [3:0] OP_INC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NEG = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_SHL = 4'b1010;
    localparam logic [3:0] OP_SHR = 4'b1011;
    localparam logic [3:0] OP_XOR = 4'b1100;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   LAST_BIT = SHW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Handshake / sequencing strobes
    logic in_ready_c;
    logic busy_c;
    logic accept;
    logic start_mul;
    logic load_single;
    logic mul_done;

    // Single-cycle datapath
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             msb_a;
    logic             msb_b;

    // Shift-and-add multiplier state
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [SHW-1:0]     cnt_q;

    // Registered output slot
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             overflow_q;
    logic             out_valid_q;

    assign sh_amt = bus.b[SHW-1:0];
    assign msb_a  = bus.a[WIDTH-1];
    assign msb_b  = bus.b[WIDTH-1];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only MUL leaves IDLE, and it returns after the last multiplier bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_mul) state_d = MULT;
            MULT: if (cnt_q == LAST_BIT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the output slot is free or draining this edge
    always_comb begin
        busy_c      = (state_q == MULT);
        in_ready_c  = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
        accept      = bus.in_valid && in_ready_c;
        start_mul   = accept && (bus.opCode == OP_MUL);
        load_single = accept && (bus.opCode != OP_MUL);
        mul_done    = (state_q == MULT) && (cnt_q == LAST_BIT);
    end

    // Single-cycle result and flags for every opcode except MUL
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = bus.a - bus.b;
        // Extra bit on the far side of each shift catches the last bit shifted out.
        shl_ext = {1'b0, bus.a} << sh_amt;
        shr_ext = {bus.a, 1'b0} >> sh_amt;
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (bus.opCode)
            OP_ADD: begin
                res_c   = sum[WIDTH-1:0];
                carry_c = sum[WIDTH];
                ovf_c   = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
            end
            OP_SUB: begin
                res_c   = diff;
                carry_c = (bus.a >= bus.b);
                ovf_c   = (msb_a != msb_b) && (diff[WIDTH-1] != msb_a);
            end
            OP_DEC: begin
                res_c   = bus.a - 1'b1;
                carry_c = (bus.a != '0);
                ovf_c   = (bus.a == SMIN);
            end
            OP_INC: begin
                res_c   = bus.a + 1'b1;
                carry_c = (bus.a == ALL_ONES);
                ovf_c   = (bus.a == SMAX);
            end
            OP_AND: res_c = bus.a & bus.b;
            OP_NEG: begin
                res_c = ~bus.a + 1'b1;
                ovf_c = (bus.a == SMIN);
            end
            OP_NOT: res_c = ~bus.a;
            OP_OR:  res_c = bus.a | bus.b;
            OP_SHL: begin
                res_c   = shl_ext[WIDTH-1:0];
                carry_c = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_c   = shr_ext[WIDTH:1];
                carry_c = shr_ext[0];
            end
            OP_XOR: res_c = bus.a ^ bus.b;
            default: begin
                res_c   = '0;
                carry_c = 1'b0;
                ovf_c   = 1'b0;
            end
        endcase
    end

    // One partial product per cycle: the multiplicand is pre-shifted, so add it when b's current LSB is set
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Multiplier registers: latch operands on accept, then shift one bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == MULT) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= mul_done ? '0 : cnt_q + 1'b1;
        end
    end

    // Output slot: load on single-cycle accept or multiply completion, hold under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (load_single) begin
            result_q    <= res_c;
            zero_q      <= (res_c == '0);
            carry_q     <= carry_c;
            overflow_q  <= ovf_c;
            out_valid_q <= 1'b1;
        end else if (mul_done) begin
            result_q    <= acc_next[WIDTH-1:0];
            zero_q      <= (acc_next[WIDTH-1:0] == '0);
            carry_q     <= (acc_next[2*WIDTH-1:WIDTH] != '0);
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on the operand values, flags from range checks
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, sa, sb, full, smax, smin, umax;
        logic [W-1:0] x;
        int s;
        exp_t e;
        ua   = a;
        ub   = b;
        sa   = $signed(a);
        sb   = $signed(b);
        umax = (longint'(1) <<< W) - 1;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        e    = '0;
        full = 0;
        x    = a;
        s    = int'(b) % W;
        case (op)
            4'd0: begin full = ua + ub; e.c = full > umax; e.v = (sa + sb > smax) || (sa + sb < smin); end
            4'd1: begin full = ua - ub; e.c = ua >= ub; e.v = (sa - sb > smax) || (sa - sb < smin); end
            4'd2: begin full = ua - 1; e.c = ua != 0; e.v = (sa - 1 < smin); end
            4'd3: begin full = ua + 1; e.c = ua == umax; e.v = (sa + 1 > smax); end
            4'd5: full = ua & ub;
            4'd6: begin full = -ua; e.v = (-sa > smax); end
            4'd7: full = ~ua;
            4'd8: full = ua | ub;
            4'd9: begin full = ua * ub; e.c = full > umax; end
            4'd10: begin
                for (int i = 0; i < s; i++) begin e.c = x[W-1]; x = x << 1; end
                full = x;
            end
            4'd11: begin
                for (int i = 0; i < s; i++) begin e.c = x[0]; x = x >> 1; end
                full = x;
            end
            4'd12: full = ua ^ ub;
            default: full = 0;
        endcase
        e.r = full[W-1:0];
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        bus.opCode   = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opCode    = '0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.result, bus.zero, bus.carry, bus.overflow, bus.out_valid, bus.busy} !== {8'h00, 5'b10000}) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%b%b%b%b%b required=00/10000", bus.result,
                     bus.zero, bus.carry, bus.overflow, bus.out_valid, bus.busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]   ops [7] = '{4'd0, 4'd1, 4'd1, 4'd10, 4'd11, 4'd4, 4'd6};
        logic [W-1:0] as  [7] = '{8'h7F, 8'h05, 8'h03, 8'h81, 8'h81, 8'h55, 8'h80};
        logic [W-1:0] bs  [7] = '{8'h01, 8'h05, 8'h05, 8'h01, 8'h09, 8'h33, 8'h00};
        exp_t e;
        exp_t got;
        for (int i = 0; i < 7; i++) begin
            send(ops[i], as[i], bs[i]);
            e = model(ops[i], as[i], bs[i]);
            @(negedge clk);
            got = {bus.result, bus.zero, bus.carry, bus.overflow};
            checks++;
            if (bus.out_valid !== 1'b1 || got !== e) begin
                failures++;
                $display("FAIL single_op%0d op=%h valid=%b got=%h/%b%b%b required=%h/%b%b%b", i, ops[i],
                         bus.out_valid, got.r, got.z, got.c, got.v, e.r, e.z, e.c, e.v);
            end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] as [2] = '{8'h10, 8'h0F};
        logic [W-1:0] bs [2] = '{8'h11, 8'h03};
        exp_t e;
        exp_t got;
        int lat, busy_n, rdy_n;
        for (int i = 0; i < 2; i++) begin
            send(4'd9, as[i], bs[i]);
            e      = model(4'd9, as[i], bs[i]);
            lat    = -1;
            busy_n = 0;
            rdy_n  = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                bus.a      = W'($urandom);
                bus.b      = W'($urandom);
                bus.opCode = 4'($urandom);
                if (bus.out_valid) begin lat = k - 1; break; end
                if (bus.busy) busy_n++;
                if (bus.in_ready) rdy_n++;
            end
            got = {bus.result, bus.zero, bus.carry, bus.overflow};
            checks++;
            if (lat !== W) begin
                failures++;
                $display("FAIL mul%0d_latency got=%0d required=%0d", i, lat, W);
            end
            checks++;
            if (busy_n !== W || rdy_n !== 0) begin
                failures++;
                $display("FAIL mul%0d_busy busy_cycles=%0d ready_cycles=%0d required=%0d/0", i, busy_n, rdy_n, W);
            end
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL mul%0d_result got=%h/%b%b%b required=%h/%b%b%b", i,
                         got.r, got.z, got.c, got.v, e.r, e.z, e.c, e.v);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e1;
        exp_t e2;
        int bad = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(4'd12, 8'hF0, 8'hFF);
        e1 = model(4'd12, 8'hF0, 8'hFF);
        e2 = model(4'd8, 8'h01, 8'h02);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.opCode   = 4'd8;
                bus.a        = 8'h01;
                bus.b        = 8'h02;
                bus.in_valid = 1'b1;
            end
            #1;
            if (!bus.out_valid || bus.in_ready || {bus.result, bus.zero, bus.carry, bus.overflow} !== e1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold bad_cycles=%0d required=0", bad);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_on_consume got=%b required=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.result, bus.zero, bus.carry, bus.overflow} !== e2) begin
            failures++;
            $display("FAIL bp_next_result valid=%b got=%h required=%h", bus.out_valid, bus.result, e2.r);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int spurious = 0;
        send(4'd9, 8'hC3, 8'h5B);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.result, bus.zero, bus.carry, bus.overflow, bus.out_valid, bus.busy} !== {8'h00, 5'b10000}) begin
            failures++;
            $display("FAIL midmul_reset got=%h/%b%b%b%b%b required=00/10000", bus.result,
                     bus.zero, bus.carry, bus.overflow, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midmul_ready got=%b required=1", bus.in_ready);
        end
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL midmul_residue cycles=%0d required=0", spurious);
        end
        send(4'd0, 8'h01, 8'h01);
        e = model(4'd0, 8'h01, 8'h01);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.result, bus.zero, bus.carry, bus.overflow} !== e) begin
            failures++;
            $display("FAIL midmul_add valid=%b got=%h required=%h", bus.out_valid, bus.result, e.r);
        end
    endtask

    // Streams random traffic through a scoreboard; full_rate forces 1 op per clock with no MUL
    task automatic run_stream(input string name, input int cycles, input bit full_rate);
        exp_t q[$];
        exp_t got;
        logic [3:0] op;
        int acc = 0;
        for (int k = 0; k < cycles + 200; k++) begin
            @(negedge clk);
            if (k >= cycles) begin
                if (q.size() == 0) break;
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end else if (full_rate) begin
                do op = 4'($urandom_range(0, 15)); while (op == 4'd9);
                bus.opCode    = op;
                bus.in_valid  = 1'b1;
                bus.out_ready = 1'b1;
            end else begin
                bus.opCode    = 4'($urandom_range(0, 15));
                bus.in_valid  = ($urandom_range(0, 1) != 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                got = {bus.result, bus.zero, bus.carry, bus.overflow};
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_spurious got=%h required=no output", name, got.r);
                end else begin
                    if (got !== q[0]) begin
                        failures++;
                        $display("FAIL %s_result got=%h/%b%b%b required=%h/%b%b%b", name,
                                 got.r, got.z, got.c, got.v, q[0].r, q[0].z, q[0].c, q[0].v);
                    end
                    void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.opCode, bus.a, bus.b));
                acc++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (q.size() !== 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, q.size());
        end
        if (full_rate) begin
            checks++;
            if (acc !== cycles) begin
                failures++;
                $display("FAIL %s_throughput accepted=%0d required=%0d", name, acc, cycles);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        run_stream("back_to_back", 40, 1'b1);
        run_stream("random", 600, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
